// File: rtl/spi_mailbox_regs.sv
// rtl/spi_mailbox_regs.sv - SPI-addressed register mailbox with TX/RX byte FIFOs
// Define SPI_MAILBOX_IRQ_EN to add the registered o_irq output and CTRL irq enables.
module spi_mailbox_regs #(
    parameter int         DEPTH    = 8,
    parameter logic [7:0] ID_VALUE = 8'hA5
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic [7:0] i_bus_addr,
    input  logic [7:0] i_bus_data,
    input  logic       i_bus_wr,
    output logic [7:0] o_bus_data,
    output logic [7:0] o_tx_data,
    output logic       o_tx_valid,
    input  logic       i_tx_ready,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_valid,
`ifdef SPI_MAILBOX_IRQ_EN
    output logic       o_rx_ready,
    output logic       o_irq
`else
    output logic       o_rx_ready
`endif
);

    localparam int            PW       = $clog2(DEPTH);
    localparam int            CW       = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
`ifdef SPI_MAILBOX_IRQ_EN
    localparam logic [7:0]    CTRL_MASK = 8'h0F;
`else
    localparam logic [7:0]    CTRL_MASK = 8'h03;
`endif

    logic [7:0]    tx_mem_q [DEPTH];
    logic [7:0]    rx_mem_q [DEPTH];
    logic [PW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [PW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [CW-1:0] tx_count_q, tx_count_d, rx_count_q, rx_count_d;
    logic [7:0]    scratch_q, scratch_d, ctrl_q, ctrl_d;
    logic          tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d, rx_udf_q, rx_udf_d;

    logic       tx_empty, tx_full, rx_empty, rx_full, tx_en, rx_en;
    logic       wr_scratch, wr_ctrl, wr_status, wr_tx, wr_rx;
    logic       tx_drain, tx_push, rx_accept, rx_pop;
    logic [7:0] rx_head, status;

    assign tx_empty = (tx_count_q == '0);
    assign tx_full  = (tx_count_q == FULL_CNT);
    assign rx_empty = (rx_count_q == '0);
    assign rx_full  = (rx_count_q == FULL_CNT);
    assign tx_en    = ctrl_q[0];
    assign rx_en    = ctrl_q[1];

    assign wr_scratch = i_bus_wr && (i_bus_addr == 8'h01);
    assign wr_ctrl    = i_bus_wr && (i_bus_addr == 8'h02);
    assign wr_status  = i_bus_wr && (i_bus_addr == 8'h03);
    assign wr_tx      = i_bus_wr && (i_bus_addr == 8'h04);
    assign wr_rx      = i_bus_wr && (i_bus_addr == 8'h05);

    assign o_tx_valid = tx_en & ~tx_empty;
    assign o_tx_data  = tx_empty ? 8'h00 : tx_mem_q[tx_rptr_q];
    assign o_rx_ready = rx_en & ~rx_full;
    assign rx_head    = rx_empty ? 8'h00 : rx_mem_q[rx_rptr_q];

    // A push into a full TX FIFO is legal when the head leaves on the same edge.
    assign tx_drain  = o_tx_valid & i_tx_ready;
    assign tx_push   = wr_tx && (!tx_full || tx_drain);
    assign rx_accept = i_rx_valid & o_rx_ready;
    assign rx_pop    = wr_rx && !rx_empty;

    assign status = {1'b0, rx_udf_q, rx_ovf_q, tx_ovf_q, rx_full, rx_empty, tx_full, tx_empty};

    always_comb begin
        o_bus_data = 8'h00;
        case (i_bus_addr)
            8'h00:   o_bus_data = ID_VALUE;
            8'h01:   o_bus_data = scratch_q;
            8'h02:   o_bus_data = ctrl_q;
            8'h03:   o_bus_data = status;
            8'h05:   o_bus_data = rx_head;
            8'h06:   o_bus_data = 8'(tx_count_q);
            8'h07:   o_bus_data = 8'(rx_count_q);
            default: o_bus_data = 8'h00;
        endcase
    end

    always_comb begin
        scratch_d  = wr_scratch ? i_bus_data : scratch_q;
        ctrl_d     = wr_ctrl ? (i_bus_data & CTRL_MASK) : ctrl_q;
        tx_wptr_d  = tx_push   ? tx_wptr_q + PW'(1) : tx_wptr_q;
        tx_rptr_d  = tx_drain  ? tx_rptr_q + PW'(1) : tx_rptr_q;
        rx_wptr_d  = rx_accept ? rx_wptr_q + PW'(1) : rx_wptr_q;
        rx_rptr_d  = rx_pop    ? rx_rptr_q + PW'(1) : rx_rptr_q;
        tx_count_d = tx_count_q + CW'(tx_push) - CW'(tx_drain);
        rx_count_d = rx_count_q + CW'(rx_accept) - CW'(rx_pop);
        // Set terms are OR'd after the clear so a same-cycle event wins over W1C.
        tx_ovf_d = (wr_tx && tx_full && !tx_drain) | (tx_ovf_q & ~(wr_status & i_bus_data[4]));
        rx_ovf_d = (rx_en && rx_full && i_rx_valid) | (rx_ovf_q & ~(wr_status & i_bus_data[5]));
        rx_udf_d = (wr_rx && rx_empty) | (rx_udf_q & ~(wr_status & i_bus_data[6]));
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            scratch_q  <= 8'h00;
            ctrl_q     <= 8'h00;
            tx_wptr_q  <= '0;
            tx_rptr_q  <= '0;
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            tx_count_q <= '0;
            rx_count_q <= '0;
            tx_ovf_q   <= 1'b0;
            rx_ovf_q   <= 1'b0;
            rx_udf_q   <= 1'b0;
        end else begin
            scratch_q  <= scratch_d;
            ctrl_q     <= ctrl_d;
            tx_wptr_q  <= tx_wptr_d;
            tx_rptr_q  <= tx_rptr_d;
            rx_wptr_q  <= rx_wptr_d;
            rx_rptr_q  <= rx_rptr_d;
            tx_count_q <= tx_count_d;
            rx_count_q <= rx_count_d;
            tx_ovf_q   <= tx_ovf_d;
            rx_ovf_q   <= rx_ovf_d;
            rx_udf_q   <= rx_udf_d;
        end
    end

    // Storage is not reset; counts and pointers alone define what is valid.
    always_ff @(posedge i_clk) begin
        if (tx_push)   tx_mem_q[tx_wptr_q] <= i_bus_data;
        if (rx_accept) rx_mem_q[rx_wptr_q] <= i_rx_data;
    end

`ifdef SPI_MAILBOX_IRQ_EN
    logic irq_q, irq_d;

    assign irq_d = (ctrl_q[2] & ~rx_empty) | (ctrl_q[3] & (tx_ovf_q | rx_ovf_q | rx_udf_q));
    assign o_irq = irq_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) irq_q <= 1'b0;
        else            irq_q <= irq_d;
    end
`endif

endmodule
